// File: rtl/window_stats_pkg.sv
// Shared types and defaults for the window statistics stage.
package window_stats_pkg;

  typedef enum logic {S_FIRST, S_ACC} state_t;

  localparam int DEF_DATA_W   = 10;
  localparam int DEF_WIN_LOG2 = 4;

  // Accumulator width: a full window of max-scale samples fits exactly.
  function automatic int sum_w(input int data_w, input int win_log2);
    return data_w + win_log2;
  endfunction

  localparam int DEF_SUM_W = DEF_DATA_W + DEF_WIN_LOG2;

endpackage

// File: rtl/strobe_edge.sv
// Registered rising-edge detector. One pulse per low->high transition of in.
// A level already high when reset releases is not treated as an edge.
module strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic r_q;
  logic r_armed;

  // History of the strobe; armed only after one post-reset cycle of sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_q     <= in;
      r_armed <= 1'b1;
    end
  end

  assign pulse = in & ~r_q & r_armed;

endmodule

// File: rtl/window_stats.sv
// Groups strobed samples into windows of 2^WIN_LOG2 and reports
// min / max / peak-to-peak / truncated mean over a valid/ready port.
module window_stats
  import window_stats_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WIN_LOG2 = DEF_WIN_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_strobe,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_p2p,
  output logic [DATA_W-1:0] out_mean,
  output logic              overrun,
  input  logic              clr_overrun
);

  localparam int SUM_W = sum_w(DATA_W, WIN_LOG2);
  localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};

  state_t              r_state;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [SUM_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   r_max;

  logic              w_take;
  logic              w_done;
  logic              w_load;
  logic [DATA_W-1:0] w_min_nx;
  logic [DATA_W-1:0] w_max_nx;
  logic [SUM_W-1:0]  w_sum_nx;

  strobe_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (in_strobe),
    .pulse(w_take)
  );

  // Running stats including the current sample; first sample seeds them
  always_comb begin
    w_min_nx = in_data;
    w_max_nx = in_data;
    w_sum_nx = SUM_W'(in_data);
    if (r_state == S_ACC) begin
      w_min_nx = (in_data < r_min) ? in_data : r_min;
      w_max_nx = (in_data > r_max) ? in_data : r_max;
      w_sum_nx = r_sum + SUM_W'(in_data);
    end
  end

  assign w_done = w_take & (r_state == S_ACC) & (r_cnt == CNT_LAST);
  // A finished window only lands if the slot is free or being drained now
  assign w_load = w_done & (~out_valid | out_ready);

  // Window FSM and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FIRST;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_min   <= '0;
      r_max   <= '0;
    end else if (w_take) begin
      r_min <= w_min_nx;
      r_max <= w_max_nx;
      r_sum <= w_sum_nx;
      case (r_state)
        S_FIRST: begin
          r_cnt   <= WIN_LOG2'(1);
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FIRST;
          end else begin
            r_cnt <= r_cnt + WIN_LOG2'(1);
          end
        end
        default: r_state <= S_FIRST;
      endcase
    end
  end

  // Output holding register with valid/ready handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_min   <= '0;
      out_max   <= '0;
      out_p2p   <= '0;
      out_mean  <= '0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_min   <= w_min_nx;
      out_max   <= w_max_nx;
      out_p2p   <= w_max_nx - w_min_nx;
      out_mean  <= w_sum_nx[SUM_W-1:WIN_LOG2];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (w_done && !w_load) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_stats.sv
// Bench for window_stats: two instances (4- and 16-sample windows) driven by
// shared stimulus, checked every cycle against a queue-style window model,
// plus directed literal expectations.
module tb_window_stats;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_strobe = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [9:0] in_data = '0;

  logic       v_a, ov_a, v_b, ov_b;
  logic [9:0] mn_a, mx_a, pp_a, me_a;
  logic [9:0] mn_b, mx_b, pp_b, me_b;

  int  checks = 0;
  int  failures = 0;
  bit  rnd = 1'b0;
  int  va_cnt = 0;

  always #5 clk = ~clk;

  window_stats #(.DATA_W(10), .WIN_LOG2(2)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe),
    .out_valid(v_a), .out_ready(out_ready), .out_min(mn_a), .out_max(mx_a),
    .out_p2p(pp_a), .out_mean(me_a), .overrun(ov_a), .clr_overrun(clr_overrun)
  );

  window_stats #(.DATA_W(10), .WIN_LOG2(4)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe),
    .out_valid(v_b), .out_ready(out_ready), .out_min(mn_b), .out_max(mx_b),
    .out_p2p(pp_b), .out_mean(me_b), .overrun(ov_b), .clr_overrun(clr_overrun)
  );

  // ---------------- reference model ----------------
  int mbuf [2][16];
  int mcnt [2];
  bit ev   [2];
  int emin [2], emax [2], emean [2];
  bit eo   [2];
  bit prev_s = 1'b0;
  bit prev_r = 1'b1;

  function automatic int win_len(input int k);
    return (k == 0) ? 4 : 16;
  endfunction

  // Inputs change just after the falling edge, so at the falling edge they
  // still show what the preceding rising edge sampled.
  task automatic model_step();
    bit take;
    take = !rst && in_strobe && !prev_s && !prev_r;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mcnt[k] = 0; ev[k] = 0; eo[k] = 0;
        emin[k] = 0; emax[k] = 0; emean[k] = 0;
      end else begin
        bit complete, dropped;
        int lo, hi, s;
        complete = 0; dropped = 0; lo = 0; hi = 0; s = 0;
        if (take) begin
          mbuf[k][mcnt[k]] = int'(in_data);
          mcnt[k]++;
          if (mcnt[k] == win_len(k)) begin
            lo = 1 << 30; hi = -1;
            for (int i = 0; i < win_len(k); i++) begin
              if (mbuf[k][i] < lo) lo = mbuf[k][i];
              if (mbuf[k][i] > hi) hi = mbuf[k][i];
              s += mbuf[k][i];
            end
            mcnt[k] = 0;
            complete = 1;
          end
        end
        if (complete) begin
          if (!ev[k] || out_ready) begin
            ev[k] = 1; emin[k] = lo; emax[k] = hi; emean[k] = s / win_len(k);
          end else begin
            dropped = 1;
          end
        end else if (ev[k] && out_ready) begin
          ev[k] = 0;
        end
        if (clr_overrun) eo[k] = 0;
        if (dropped) eo[k] = 1;
      end
    end
    prev_s = in_strobe;
    prev_r = rst;
  endtask

  task automatic cmp(input int k, input bit v, input int mn, input int mx,
                     input int pp, input int me, input bit ov);
    checks++;
    if (v !== ev[k] || mn != emin[k] || mx != emax[k] || pp != emax[k] - emin[k] ||
        me != emean[k] || ov !== eo[k]) begin
      failures++;
      $display("FAIL model_cmp dut%0d t=%0t got v=%0d min=%0d max=%0d p2p=%0d mean=%0d ov=%0d want v=%0d min=%0d max=%0d p2p=%0d mean=%0d ov=%0d",
               k, $time, v, mn, mx, pp, me, ov, ev[k], emin[k], emax[k],
               emax[k] - emin[k], emean[k], eo[k]);
    end
  endtask

  // Model update and per-cycle comparison
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      cmp(0, v_a, int'(mn_a), int'(mx_a), int'(pp_a), int'(me_a), ov_a);
      cmp(1, v_b, int'(mn_b), int'(mx_b), int'(pp_b), int'(me_b), ov_b);
      if (v_a) va_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (rnd) begin
      out_ready   = 1'($urandom_range(0, 1));
      clr_overrun = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic samp(input int d, input int h, input int g);
    in_data = 10'(d);
    in_strobe = 1'b1;
    repeat (h) tick();
    in_strobe = 1'b0;
    in_data = 10'($urandom);
    repeat (g) tick();
  endtask

  // Drive the final sample of a window high for one cycle, leave strobe high
  task automatic last_hi(input int d);
    in_data = 10'(d);
    in_strobe = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    lit("reset_valid", int'(v_a), 0);
    lit("reset_overrun", int'(ov_b), 0);
    lit("reset_min", int'(mn_a), 0);
    rst = 1'b0; tick();

    // Basic window
    out_ready = 1'b1;
    samp(100, 1, 1); samp(300, 1, 1); samp(200, 1, 1);
    last_hi(50);
    lit("basic_valid", int'(v_a), 1);
    lit("basic_min", int'(mn_a), 50);
    lit("basic_max", int'(mx_a), 300);
    lit("basic_p2p", int'(pp_a), 250);
    lit("basic_mean", int'(me_a), 162);
    in_strobe = 1'b0; tick();
    lit("basic_drained", int'(v_a), 0);

    // Full scale on the 16-sample window
    do_reset();
    for (int i = 0; i < 15; i++) samp(1023, 1, 1);
    last_hi(1023);
    lit("full_valid", int'(v_b), 1);
    lit("full_min", int'(mn_b), 1023);
    lit("full_max", int'(mx_b), 1023);
    lit("full_p2p", int'(pp_b), 0);
    lit("full_mean", int'(me_b), 1023);
    in_strobe = 1'b0; tick();

    // Level strobe held 7 cycles per sample
    do_reset();
    va_cnt = 0;
    for (int i = 0; i < 4; i++) samp(40 + i, 7, 2);
    tick(); tick();
    lit("level_results", va_cnt, 1);

    // Overrun: two windows with no consumer
    do_reset();
    out_ready = 1'b0;
    samp(10, 1, 1); samp(20, 1, 1); samp(30, 1, 1); samp(40, 1, 1);
    samp(5, 1, 1); samp(5, 1, 1); samp(5, 1, 1); samp(5, 1, 1);
    lit("ovr_valid", int'(v_a), 1);
    lit("ovr_min", int'(mn_a), 10);
    lit("ovr_max", int'(mx_a), 40);
    lit("ovr_flag", int'(ov_a), 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0; tick();
    lit("ovr_cleared", int'(ov_a), 0);

    // Same-cycle replace of a held result
    samp(7, 1, 1); samp(8, 1, 1); samp(9, 1, 1);
    out_ready = 1'b1;
    last_hi(6);
    lit("repl_valid", int'(v_a), 1);
    lit("repl_min", int'(mn_a), 6);
    lit("repl_max", int'(mx_a), 9);
    lit("repl_mean", int'(me_a), 7);
    lit("repl_overrun", int'(ov_a), 0);
    in_strobe = 1'b0; tick(); tick();

    // Reset mid-window, strobe already high when reset releases
    samp(111, 1, 1); samp(222, 1, 1);
    rst = 1'b1; in_data = 10'd999; in_strobe = 1'b1; tick();
    lit("rst_min_zero", int'(mn_a), 0);
    lit("rst_mean_zero", int'(me_a), 0);
    lit("rst_valid_zero", int'(v_a), 0);
    rst = 1'b0; tick(); tick();
    in_strobe = 1'b0; tick();
    samp(500, 1, 1); samp(500, 1, 1); samp(500, 1, 1);
    last_hi(500);
    lit("rst_after_valid", int'(v_a), 1);
    lit("rst_after_min", int'(mn_a), 500);
    lit("rst_after_max", int'(mx_a), 500);
    lit("rst_after_mean", int'(me_a), 500);
    in_strobe = 1'b0; tick();

    // Randomized traffic against the model
    rnd = 1'b1;
    for (int i = 0; i < 500; i++) begin
      int d;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
      case ($urandom_range(0, 5))
        0: d = 0;
        1: d = 1023;
        default: d = int'($urandom_range(0, 1023));
      endcase
      samp(d, int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
    end
    rnd = 1'b0;
    out_ready = 1'b1; clr_overrun = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
